// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle multiply/divide companion to the EX stage.
// Owns the architected HI/LO registers and stalls the pipeline while an
// iterative shift-add multiply or restoring divide is in flight.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle MULT/MULTU).
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              annul,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   ONES_W   = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Magnitude of a value, treating it as two's complement only when sgn is set.
  function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Conditional two's complement negation, single width.
  function automatic logic [DATA_W-1:0] neg_w_f(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Conditional two's complement negation, double width.
  function automatic logic [2*DATA_W-1:0] neg_2w_f(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(2*DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [DATA_W-1:0]   hi_r, hi_next_s;
  logic [DATA_W-1:0]   lo_r, lo_next_s;
  // acc_r: multiply = {partial product, remaining multiplier bits};
  //        divide   = {partial remainder, dividend bits becoming quotient}.
  logic [2*DATA_W-1:0] acc_r, acc_next_s;
  // opd_r: multiplicand magnitude or divisor magnitude.
  logic [DATA_W-1:0]   opd_r, opd_next_s;
  logic                neg_res_r, neg_res_next_s;
  logic                neg_rem_r, neg_rem_next_s;
  logic                done_r, busy_r;
  logic                stallreq_s;
  logic                sgn_s;

  logic [DATA_W:0]     mul_sum_s;
  logic [2*DATA_W-1:0] mul_step_s;
  logic [DATA_W:0]     div_shift_s;
  logic [DATA_W:0]     div_diff_s;
  logic                div_ge_s;
  logic [DATA_W-1:0]   div_rem_s;
  logic [2*DATA_W-1:0] div_step_s;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_a_s, fast_b_s, fast_prod_s;

  // Single-cycle product of sign- or zero-extended operands (low 2*DATA_W bits are exact).
  always_comb begin
    fast_a_s    = {{DATA_W{sgn_s & opa[DATA_W-1]}}, opa};
    fast_b_s    = {{DATA_W{sgn_s & opb[DATA_W-1]}}, opb};
    fast_prod_s = fast_a_s * fast_b_s;
  end
`endif

  // One shift-add multiply step and one restoring-divide step on the shared accumulator.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                  (acc_r[0] ? {1'b0, opd_r} : {(DATA_W+1){1'b0}});
    mul_step_s  = {mul_sum_s, acc_r[DATA_W-1:1]};
    div_shift_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
    div_diff_s  = div_shift_s - {1'b0, opd_r};
    div_ge_s    = (div_shift_s >= {1'b0, opd_r});
    if (div_ge_s) begin
      div_rem_s = div_diff_s[DATA_W-1:0];
    end else begin
      div_rem_s = div_shift_s[DATA_W-1:0];
    end
    div_step_s  = {div_rem_s, acc_r[DATA_W-2:0], div_ge_s};
  end

  // Next-state, datapath load and stall request.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    hi_next_s      = hi_r;
    lo_next_s      = lo_r;
    acc_next_s     = acc_r;
    opd_next_s     = opd_r;
    neg_res_next_s = neg_res_r;
    neg_rem_next_s = neg_rem_r;
    stallreq_s     = 1'b0;
    sgn_s          = (op == OP_MULT) || (op == OP_DIV);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        state_next_s = ST_IDLE;
        if (start && !annul) begin
          case (op)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_next_s, lo_next_s} = fast_prod_s;
              state_next_s           = ST_DONE;
`else
              stallreq_s     = 1'b1;
              opd_next_s     = mag_f(opa, sgn_s);
              acc_next_s     = {ZERO_W, mag_f(opb, sgn_s)};
              neg_res_next_s = sgn_s & (opa[DATA_W-1] ^ opb[DATA_W-1]);
              cnt_next_s     = CNT_ZERO;
              state_next_s   = ST_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              stallreq_s = 1'b1;
              if (opb == ZERO_W) begin
                hi_next_s    = opa;
                lo_next_s    = ONES_W;
                state_next_s = ST_DONE;
              end else begin
                opd_next_s     = mag_f(opb, sgn_s);
                acc_next_s     = {ZERO_W, mag_f(opa, sgn_s)};
                neg_res_next_s = sgn_s & (opa[DATA_W-1] ^ opb[DATA_W-1]);
                neg_rem_next_s = sgn_s & opa[DATA_W-1];
                cnt_next_s     = CNT_ZERO;
                state_next_s   = ST_DIV;
              end
            end
            OP_MTHI: begin
              hi_next_s = opa;
            end
            OP_MTLO: begin
              lo_next_s = opa;
            end
            default: begin
              state_next_s = ST_IDLE;
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (annul) begin
          state_next_s = ST_IDLE;
        end else begin
          stallreq_s = 1'b1;
          acc_next_s = mul_step_s;
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            {hi_next_s, lo_next_s} = neg_2w_f(mul_step_s, neg_res_r);
            cnt_next_s             = CNT_ZERO;
            state_next_s           = ST_DONE;
          end else begin
            state_next_s = ST_MUL;
          end
        end
      end
      ST_DIV: begin
        if (annul) begin
          state_next_s = ST_IDLE;
        end else begin
          stallreq_s = 1'b1;
          acc_next_s = div_step_s;
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            lo_next_s    = neg_w_f(div_step_s[DATA_W-1:0], neg_res_r);
            hi_next_s    = neg_w_f(div_step_s[2*DATA_W-1:DATA_W], neg_rem_r);
            cnt_next_s   = CNT_ZERO;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_DIV;
          end
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, HI/LO and datapath registers; registered done/busy decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      acc_r     <= {2*DATA_W{1'b0}};
      opd_r     <= ZERO_W;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      hi_r      <= hi_next_s;
      lo_r      <= lo_next_s;
      acc_r     <= acc_next_s;
      opd_r     <= opd_next_s;
      neg_res_r <= neg_res_next_s;
      neg_rem_r <= neg_rem_next_s;
      done_r    <= (state_next_s == ST_DONE);
      busy_r    <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV);
    end
  end

  assign stallreq = stallreq_s;
  assign busy     = busy_r;
  assign done     = done_r;
  assign hi_o     = hi_r;
  assign lo_o     = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit (DATA_W=32).
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .annul    (annul),
    .stallreq (stallreq),
    .busy     (busy),
    .done     (done),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi_o, lo_o);
      end else begin
        chk(name_q.pop_front(), {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  // Issue one op from the current cycle, count stall cycles, end in the following cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input bit exp_done, input logic [63:0] exp_val,
                        input string nm);
    int n;
    if (exp_done) begin
      exp_q.push_back(exp_val);
      name_q.push_back(nm);
    end
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    #1;
    n = 0;
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      #1;
    end
    if (n == 0) begin
      @(negedge clk);
      start = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      #1;
    end
    chk({nm, "_stall"}, 64'(n), 64'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    opa   = 32'd0;
    opb   = 32'd0;
    annul = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_hilo", {hi_o, lo_o}, 64'h0);
    chk("reset_flags", {61'd0, done, busy, stallreq}, 64'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, MUL_STALL, 1'b1, 64'h0000_0001_FFFF_FFFE, "multu");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, MUL_STALL, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, MUL_STALL, 1'b1, 64'h4000_0000_0000_0000, "mult_minmin");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run_op(3'd3, 32'd100, 32'd7, 33, 1'b1, 64'h0000_0002_0000_000E, "divu");
    run_op(3'd3, 32'd100, 32'd0, 1, 1'b1, 64'h0000_0064_FFFF_FFFF, "divu_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 64'h0000_0000_8000_0000, "div_ovf");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 33, 1'b1, 64'h0000_0001_FFFF_FFFD, "div_negdiv");

    // Annul a divide at iteration 10: HI/LO keep 1 / FFFFFFFD, no done.
    start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("annul_busy_before", {63'd0, busy}, 64'd1);
    annul = 1'b1;
    #1;
    chk("annul_stallreq", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_idle", {62'd0, busy, stallreq}, 64'd0);
    chk("annul_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
    repeat (40) @(negedge clk);
    #1;

    // Reset at iteration 20 of a second divide clears HI/LO.
    start = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    chk("rst_mid_flags", {61'd0, done, busy, stallreq}, 64'h0);

    // Back-to-back MTHI / MTLO, then DIVU followed by DIV accepted in DONE.
    run_op(3'd4, 32'h1234_5678, 32'd0, 0, 1'b0, 64'h0, "mthi");
    chk("mthi_hi", {32'd0, hi_o}, 64'h0000_0000_1234_5678);
    run_op(3'd5, 32'h0000_0009, 32'd0, 0, 1'b0, 64'h0, "mtlo");
    chk("mtlo_hilo", {hi_o, lo_o}, 64'h1234_5678_0000_0009);
    run_op(3'd3, 32'd100, 32'd7, 33, 1'b1, 64'h0000_0002_0000_000E, "divu_b2b");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_in_done");

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
